// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants: the {pc, instr} entry carried to decode
// and the canonical NOP returned before anything has been fetched.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic fetch_entry_t reset_entry();
    fetch_entry_t e;
    e.pc    = 32'h0000_0000;
    e.instr = NOP_INSTR;
    return e;
  endfunction

endpackage

// File: rtl/fetch_chk.sv
// Invariant checker for the fetch stage; carries no functional logic.
module fetch_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic [31:0]      i_index,
  input logic [CNT_W-1:0] i_count
);

  a_index_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    i_index[1:0] == 2'b00);

  a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    i_count <= CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with push/pop/flush. Pointers wrap naturally
// because DEPTH is a power of two; count is one bit wider to represent "full".
module fetch_queue
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_wdata,
  output fetch_entry_t     o_rdata,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  fetch_entry_t     r_mem [DEPTH];

  // Next pointer/count; flush wins over any concurrent push or pop.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_head_nxt  = {PTR_W{1'b0}};
      w_tail_nxt  = {PTR_W{1'b0}};
      w_count_nxt = {CNT_W{1'b0}};
    end else begin
      if (i_push) begin
        w_tail_nxt = r_tail + PTR_W'(1);
      end else begin
        w_tail_nxt = r_tail;
      end
      if (i_pop) begin
        w_head_nxt = r_head + PTR_W'(1);
      end else begin
        w_head_nxt = r_head;
      end
      case ({i_push, i_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Entry storage; reset to NOP so the head reads as NOP at pc 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= reset_entry();
      end
    end else if (i_push && !i_flush) begin
      r_mem[r_tail] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_valid = (r_count != {CNT_W{1'b0}});
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, indexes imem, and queues {pc, instr} for decode.
// Redirects flush the queue and reload the PC; a concurrent pop is still accepted.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          PC_STEP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_index,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_en,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_wdata;
  fetch_entry_t     w_head;

  // Handshake and PC selection; redirect has priority and suppresses the push.
  always_comb begin
    w_pop    = dec_valid & dec_ready;
    w_push   = fetch_en & ~redirect_valid &
               ((w_count < CNT_W'(QUEUE_DEPTH)) | w_pop);
    w_pc_nxt = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = align_word(redirect_pc);
    end else if (w_push) begin
      w_pc_nxt = r_pc + 32'(PC_STEP);
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = imem_instr;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_valid (dec_valid),
    .o_count (w_count)
  );

  fetch_chk #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_index (r_pc),
    .i_count (w_count)
  );

  assign imem_index = r_pc;
  assign dec_instr  = w_head.instr;
  assign dec_pc     = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a behavioural imem whose word
// content is a fixed function of its address.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_index;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_en;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int checks;
  int errors;

  typedef struct {
    bit          rst;
    bit          fe;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eidx;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0003;
  endfunction

  assign imem_instr = imem_word(imem_index);

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_index     (imem_index),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_en       (fetch_en),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, exp);
    end
  endtask

  task automatic add(input bit rst, input bit fe, input bit rdy, input bit rv,
                     input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                     input logic [31:0] eidx);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eidx = eidx;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    fetch_en       = 1'b0;
    dec_ready      = 1'b0;
    rst_n          = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    fetch_en = 1'b0;
    dec_ready = 1'b0;

    // Streaming with decode always ready.
    add(1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h00);
    add(0, 1, 1, 0, 32'h0, 1, 32'h00, 32'h04);
    add(0, 1, 1, 0, 32'h0, 1, 32'h04, 32'h08);
    add(0, 1, 1, 0, 32'h0, 1, 32'h08, 32'h0C);
    add(0, 1, 1, 0, 32'h0, 1, 32'h0C, 32'h10);
    // Back-pressure for 5 cycles, then drain in order.
    add(1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h00);
    add(0, 1, 0, 0, 32'h0, 1, 32'h00, 32'h04);
    add(0, 1, 0, 0, 32'h0, 1, 32'h00, 32'h08);
    add(0, 1, 0, 0, 32'h0, 1, 32'h00, 32'h08);
    add(0, 1, 0, 0, 32'h0, 1, 32'h00, 32'h08);
    add(0, 1, 1, 0, 32'h0, 1, 32'h00, 32'h08);
    add(0, 1, 1, 0, 32'h0, 1, 32'h04, 32'h0C);
    add(0, 1, 1, 0, 32'h0, 1, 32'h08, 32'h10);
    add(0, 1, 1, 0, 32'h0, 1, 32'h0C, 32'h14);
    // Redirect to unaligned 0x23 at cycle 4.
    add(1, 1, 1, 0, 32'h0, 0, 32'h0, 32'h00);
    add(0, 1, 1, 0, 32'h0, 1, 32'h00, 32'h04);
    add(0, 1, 1, 0, 32'h0, 1, 32'h04, 32'h08);
    add(0, 1, 1, 0, 32'h0, 1, 32'h08, 32'h0C);
    add(0, 1, 1, 1, 32'h23, 1, 32'h0C, 32'h10);
    add(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h20);
    add(0, 1, 1, 0, 32'h0, 1, 32'h20, 32'h24);
    add(0, 1, 1, 0, 32'h0, 1, 32'h24, 32'h28);
    // Redirect while full and popping.
    add(1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h00);
    add(0, 1, 0, 0, 32'h0, 1, 32'h00, 32'h04);
    add(0, 1, 0, 0, 32'h0, 1, 32'h00, 32'h08);
    add(0, 1, 1, 1, 32'h100, 1, 32'h00, 32'h08);
    add(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h100);
    add(0, 1, 1, 0, 32'h0, 1, 32'h100, 32'h104);
    add(0, 1, 1, 0, 32'h0, 1, 32'h104, 32'h108);
    // PC wrap at the top of the address space.
    add(1, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0);
    add(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFF8);
    add(0, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    add(0, 1, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0000_0000);
    add(0, 1, 1, 0, 32'h0, 1, 32'h0000_0000, 32'h0000_0004);
    // fetch_en low holds the PC and stops pushes.
    add(1, 0, 1, 0, 32'h0, 0, 32'h0, 32'h00);
    add(0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h00);
    add(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h00);
    add(0, 1, 1, 0, 32'h0, 1, 32'h00, 32'h04);
    add(0, 0, 1, 0, 32'h0, 1, 32'h04, 32'h08);
    add(0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h08);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        #1;
        chk("rst_valid", i, {31'h0, dec_valid}, 32'h0);
        chk("rst_instr", i, dec_instr, 32'h0000_0013);
        chk("rst_pc", i, dec_pc, 32'h0);
      end
      fetch_en       = vecs[i].fe;
      dec_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk("valid", i, {31'h0, dec_valid}, {31'h0, vecs[i].ev});
      chk("index", i, imem_index, vecs[i].eidx);
      if (vecs[i].ev) begin
        chk("dec_pc", i, dec_pc, vecs[i].epc);
        chk("dec_instr", i, dec_instr, imem_word(vecs[i].epc));
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-stream with a full queue.
    do_reset();
    fetch_en  = 1'b1;
    dec_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_valid", 100, {31'h0, dec_valid}, 32'h1);
    chk("pre_rst_index", 100, imem_index, 32'h8);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 101, {31'h0, dec_valid}, 32'h0);
    chk("async_index", 101, imem_index, 32'h0);
    chk("async_pc", 101, dec_pc, 32'h0);
    chk("async_instr", 101, dec_instr, 32'h0000_0013);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("restart_valid", 102 + k, {31'h0, dec_valid}, 32'h1);
      chk("restart_pc", 102 + k, dec_pc, 32'(k * 4));
      chk("restart_instr", 102 + k, dec_instr, imem_word(32'(k * 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
